// File: rtl/mem_pkg.sv
// Shared LSU types: memory op codes, FSM state encoding, constants.
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB,
    MEM_LBU,
    MEM_LH,
    MEM_LHU,
    MEM_LW,
    MEM_SB,
    MEM_SH,
    MEM_SW,
    MEM_LL,
    MEM_SC
  } mem_op_t;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t S_IDLE = 2'd0;
  localparam lsu_state_t S_WAIT = 2'd1;
  localparam lsu_state_t S_DONE = 2'd2;

  localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

endpackage

// File: rtl/mem_lsu_if.sv
// Req/ack data bus between the LSU (master) and memory (slave).
interface mem_lsu_if #(
  parameter int ADDR_W = 32
);

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_sel;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_sel,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_sel,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );

endinterface

// File: rtl/mem_align.sv
// Big-endian byte-lane select/extend for loads, sel and lane replication for stores.
module mem_align
  import mem_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  ofs,
  input  logic [31:0] rdata,
  input  logic [31:0] sdata,
  output logic [31:0] ldata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic        misalign
);

  logic [7:0]  lb;
  logic [15:0] lh;
  logic [3:0]  bsel;
  logic [3:0]  hsel;

  always_comb begin
    unique case (ofs)
      2'd0:    lb = rdata[31:24];
      2'd1:    lb = rdata[23:16];
      2'd2:    lb = rdata[15:8];
      default: lb = rdata[7:0];
    endcase
  end

  assign lh   = ofs[1] ? rdata[15:0] : rdata[31:16];
  assign bsel = 4'b1000 >> ofs;
  assign hsel = ofs[1] ? 4'b0011 : 4'b1100;

  always_comb begin
    ldata    = WORD_ZERO;
    sel      = 4'b0000;
    wdata    = WORD_ZERO;
    misalign = 1'b0;
    unique case (op)
      MEM_LB: begin
        ldata = {{24{lb[7]}}, lb};
        sel   = bsel;
      end
      MEM_LBU: begin
        ldata = {24'h0, lb};
        sel   = bsel;
      end
      MEM_LH: begin
        ldata    = {{16{lh[15]}}, lh};
        sel      = hsel;
        misalign = ofs[0];
      end
      MEM_LHU: begin
        ldata    = {16'h0, lh};
        sel      = hsel;
        misalign = ofs[0];
      end
      MEM_LW, MEM_LL: begin
        ldata    = rdata;
        sel      = 4'b1111;
        misalign = |ofs;
      end
      MEM_SB: begin
        sel   = bsel;
        wdata = {4{sdata[7:0]}};
      end
      MEM_SH: begin
        sel      = hsel;
        wdata    = {2{sdata[15:0]}};
        misalign = ofs[0];
      end
      MEM_SW, MEM_SC: begin
        sel      = 4'b1111;
        wdata    = sdata;
        misalign = |ofs;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MIPS memory stage: req/ack bus access, LL/SC link resolution, result mux.
// MEM_LSU_FASTACK_EN: an ack in the first request cycle completes with no stall.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int   ADDR_W    = 32,
  parameter logic LLBIT_RST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic [4:0]        ex_wd,
  input  logic [31:0]       ex_wdata,
  input  logic              ex_wreg,
  input  logic              ex_whilo,
  input  logic [31:0]       ex_hi,
  input  logic [31:0]       ex_lo,
  input  logic [3:0]        ex_mem_op,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [31:0]       ex_store_data,
  input  logic              LLbit_i,
  input  logic              wb_LLbit_we,
  input  logic              wb_LLbit_value,
  mem_lsu_if.master         bus,
  output logic [4:0]        mem_wd,
  output logic [31:0]       mem_wdata,
  output logic              mem_wreg,
  output logic              mem_whilo,
  output logic [31:0]       mem_hi,
  output logic [31:0]       mem_lo,
  output logic              mem_LLbit_we,
  output logic              mem_LLbit_value,
  output logic              mem_misalign,
  output logic              stallreq_from_mem
);

  lsu_state_t        state;
  lsu_state_t        nxt;
  mem_op_t           op;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        sel_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rdata_src;
  logic [31:0]       ld_data;
  logic [31:0]       st_data;
  logic [3:0]        lane_sel;
  logic              mis;
  logic              is_load;
  logic              is_store;
  logic              is_sc;
  logic              link;
  logic              sc_fail;
  logic              access;
  logic              done;
  logic              unused;

  assign op     = mem_op_t'(ex_mem_op);
  assign unused = ^{stall[5], stall[3:0]};

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    unique case (op)
      MEM_LB, MEM_LBU, MEM_LH,
      MEM_LHU, MEM_LW, MEM_LL: is_load = 1'b1;
      MEM_SB, MEM_SH,
      MEM_SW, MEM_SC:          is_store = 1'b1;
      default: ;
    endcase
  end

  // The writeback stage may be committing a newer link value this cycle.
  assign is_sc   = (op == MEM_SC);
  assign link    = wb_LLbit_we ? wb_LLbit_value
                 : (rst ? LLBIT_RST : LLbit_i);
  assign sc_fail = is_sc & ~link;
  assign access  = (is_load | is_store) & ~mis & ~sc_fail;

  // Fast completion reads the bus directly; otherwise the latched word.
  assign rdata_src = (state == S_IDLE) ? bus.bus_rdata : rdata_q;

  mem_align u_align (
    .op       (op),
    .ofs      (ex_mem_addr[1:0]),
    .rdata    (rdata_src),
    .sdata    (ex_store_data),
    .ldata    (ld_data),
    .sel      (lane_sel),
    .wdata    (st_data),
    .misalign (mis)
  );

  always_comb begin
    nxt               = state;
    bus.bus_req       = 1'b0;
    bus.bus_we        = 1'b0;
    bus.bus_addr      = '0;
    bus.bus_sel       = 4'b0000;
    bus.bus_wdata     = WORD_ZERO;
    stallreq_from_mem = 1'b0;
    done              = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (access) begin
          bus.bus_req       = 1'b1;
          bus.bus_we        = is_store;
          bus.bus_addr      = {ex_mem_addr[ADDR_W-1:2], 2'b00};
          bus.bus_sel       = lane_sel;
          bus.bus_wdata     = st_data;
          stallreq_from_mem = 1'b1;
          nxt               = S_WAIT;
          if (bus.bus_ack) begin
`ifdef MEM_LSU_FASTACK_EN
            stallreq_from_mem = 1'b0;
            done              = 1'b1;
            nxt               = stall[4] ? S_DONE : S_IDLE;
`else
            nxt = S_DONE;
`endif
          end
        end
      end
      S_WAIT: begin
        bus.bus_req       = 1'b1;
        bus.bus_we        = we_q;
        bus.bus_addr      = addr_q;
        bus.bus_sel       = sel_q;
        bus.bus_wdata     = wdata_q;
        stallreq_from_mem = 1'b1;
        if (bus.bus_ack) nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (!stall[4]) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    if (rst) begin
      bus.bus_req       = 1'b0;
      bus.bus_we        = 1'b0;
      bus.bus_addr      = '0;
      bus.bus_sel       = 4'b0000;
      bus.bus_wdata     = WORD_ZERO;
      stallreq_from_mem = 1'b0;
    end
  end

  always_comb begin
    mem_wd          = ex_wd;
    mem_wdata       = ex_wdata;
    mem_wreg        = ex_wreg;
    mem_whilo       = ex_whilo;
    mem_hi          = ex_hi;
    mem_lo          = ex_lo;
    mem_LLbit_we    = 1'b0;
    mem_LLbit_value = 1'b0;
    mem_misalign    = 1'b0;
    priority case (1'b1)
      rst: begin
        mem_wd    = 5'd0;
        mem_wdata = WORD_ZERO;
        mem_wreg  = 1'b0;
        mem_whilo = 1'b0;
        mem_hi    = WORD_ZERO;
        mem_lo    = WORD_ZERO;
      end
      done: begin
        if (is_load) mem_wdata = ld_data;
        if (op == MEM_LL) begin
          mem_LLbit_we    = 1'b1;
          mem_LLbit_value = 1'b1;
        end
        if (is_sc) begin
          mem_wdata       = 32'd1;
          mem_wreg        = 1'b1;
          mem_LLbit_we    = 1'b1;
          mem_LLbit_value = 1'b0;
        end
      end
      stallreq_from_mem: mem_wreg = 1'b0;
      mis: begin
        mem_misalign = 1'b1;
        mem_wreg     = 1'b0;
      end
      sc_fail: begin
        mem_wdata = WORD_ZERO;
        mem_wreg  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      sel_q   <= 4'b0000;
      we_q    <= 1'b0;
      wdata_q <= WORD_ZERO;
      rdata_q <= WORD_ZERO;
    end else begin
      state <= nxt;
      if (state == S_IDLE && access) begin
        addr_q  <= bus.bus_addr;
        sel_q   <= bus.bus_sel;
        we_q    <= bus.bus_we;
        wdata_q <= bus.bus_wdata;
      end
      if (bus.bus_req && bus.bus_ack) rdata_q <= bus.bus_rdata;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: vector table plus multi-cycle sequences.
module tb_mem_lsu;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_store_data, ex_mem_addr;
  logic        ex_wreg, ex_whilo;
  logic [3:0]  ex_mem_op;
  logic        LLbit_i, wb_LLbit_we, wb_LLbit_value;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_wreg, mem_whilo, mem_LLbit_we, mem_LLbit_value;
  logic        mem_misalign, stallreq_from_mem;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n;

`ifdef MEM_LSU_FASTACK_EN
  localparam int IMM_STALLS = 0;
`else
  localparam int IMM_STALLS = 1;
`endif

  mem_lsu_if #(.ADDR_W(32)) bus_if ();

  mem_lsu #(.ADDR_W(32), .LLBIT_RST(1'b0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_wd(ex_wd), .ex_wdata(ex_wdata), .ex_wreg(ex_wreg),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr),
    .ex_store_data(ex_store_data), .LLbit_i(LLbit_i),
    .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
    .bus(bus_if),
    .mem_wd(mem_wd), .mem_wdata(mem_wdata), .mem_wreg(mem_wreg),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_LLbit_we(mem_LLbit_we), .mem_LLbit_value(mem_LLbit_value),
    .mem_misalign(mem_misalign), .stallreq_from_mem(stallreq_from_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdata;
    logic        ll_i;
    logic        wb_we;
    logic        wb_val;
    logic        wreg;
    logic        req;
    logic        we;
    logic [31:0] baddr;
    logic [3:0]  sel;
    logic [31:0] bwdata;
    logic        stl;
    logic        chk_res;
    logic [31:0] res;
    logic        rwreg;
    logic        mis;
  } vec_t;

  typedef struct {
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] res;
  } ld_t;

  vec_t vecs[14];
  ld_t  lds[5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_op(input mem_op_t op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic wreg);
    ex_mem_op     = op;
    ex_mem_addr   = addr;
    ex_store_data = sdata;
    ex_wreg       = wreg;
  endtask

  // Counts stall cycles; raises ack once ack_at stall cycles have been seen.
  task automatic access(input int ack_at, output int stalls);
    stalls = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!stallreq_from_mem) return;
      stalls++;
      if (stalls == ack_at) bus_if.bus_ack = 1'b1;
      @(posedge clk);
      #1;
      bus_if.bus_ack = 1'b0;
    end
    chk("access_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{MEM_NONE, 32'h0, 32'h1234, 32'h0, 0, 0, 0, 1,
                 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 32'h1234, 1, 0};
    vecs[1]  = '{MEM_SH, 32'h202, 32'h0, 32'hABCD, 0, 0, 0, 0,
                 1, 1, 32'h200, 4'b0011, 32'hABCDABCD, 1, 0, 32'h0, 0, 0};
    vecs[2]  = '{MEM_SB, 32'h101, 32'h0, 32'h5A, 0, 0, 0, 0,
                 1, 1, 32'h100, 4'b0100, 32'h5A5A5A5A, 1, 0, 32'h0, 0, 0};
    vecs[3]  = '{MEM_SW, 32'h300, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0,
                 1, 1, 32'h300, 4'b1111, 32'hDEADBEEF, 1, 0, 32'h0, 0, 0};
    vecs[4]  = '{MEM_LH, 32'h10, 32'h0, 32'h0, 0, 0, 0, 0,
                 1, 0, 32'h10, 4'b1100, 32'h0, 1, 0, 32'h0, 0, 0};
    vecs[5]  = '{MEM_LB, 32'h103, 32'h0, 32'h0, 0, 0, 0, 0,
                 1, 0, 32'h100, 4'b0001, 32'h0, 1, 0, 32'h0, 0, 0};
    vecs[6]  = '{MEM_LW, 32'h2, 32'h77, 32'h0, 0, 0, 0, 1,
                 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, 0, 1};
    vecs[7]  = '{MEM_LHU, 32'h3, 32'h77, 32'h0, 0, 0, 0, 1,
                 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, 0, 1};
    vecs[8]  = '{MEM_SH, 32'h201, 32'h0, 32'h1111, 0, 0, 0, 1,
                 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, 0, 1};
    vecs[9]  = '{MEM_SC, 32'h40, 32'h55, 32'h9, 0, 0, 0, 1,
                 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 32'h0, 1, 0};
    vecs[10] = '{MEM_SC, 32'h40, 32'h55, 32'h9, 1, 1, 0, 1,
                 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 32'h0, 1, 0};
    vecs[11] = '{MEM_SC, 32'h41, 32'h55, 32'h9, 1, 0, 0, 1,
                 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, 0, 1};
    vecs[12] = '{MEM_SC, 32'h44, 32'h0, 32'hCAFEF00D, 0, 1, 1, 0,
                 1, 1, 32'h44, 4'b1111, 32'hCAFEF00D, 1, 0, 32'h0, 0, 0};
    vecs[13] = '{MEM_LBU, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0,
                 1, 0, 32'h0, 4'b1000, 32'h0, 1, 0, 32'h0, 0, 0};

    lds[0] = '{MEM_LBU, 32'h101, 32'h12AB3456, 32'h000000AB};
    lds[1] = '{MEM_LB,  32'h100, 32'h80FFFFFF, 32'hFFFFFF80};
    lds[2] = '{MEM_LH,  32'h2,   32'h12348001, 32'hFFFF8001};
    lds[3] = '{MEM_LHU, 32'h0,   32'hFEDC0000, 32'h0000FEDC};
    lds[4] = '{MEM_LW,  32'h8,   32'hA5A50F0F, 32'hA5A50F0F};

    rst = 1'b1;
    stall = 6'd0;
    ex_wd = 5'd5;
    ex_wdata = 32'h99;
    ex_whilo = 1'b1;
    ex_hi = 32'h11;
    ex_lo = 32'h22;
    LLbit_i = 1'b0;
    wb_LLbit_we = 1'b0;
    wb_LLbit_value = 1'b0;
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = 32'h0;
    set_op(MEM_LW, 32'h10, 32'h0, 1'b1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", bus_if.bus_req, 0);
    chk("rst_stall", stallreq_from_mem, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wreg", mem_wreg, 0);
    chk("rst_hi", mem_hi, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ex_mem_op = MEM_NONE;

    for (int i = 0; i < 14; i++) begin
      set_op(vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].wreg);
      ex_wdata       = vecs[i].wdata;
      LLbit_i        = vecs[i].ll_i;
      wb_LLbit_we    = vecs[i].wb_we;
      wb_LLbit_value = vecs[i].wb_val;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), bus_if.bus_req, vecs[i].req);
      chk($sformatf("v%0d_stall", i), stallreq_from_mem, vecs[i].stl);
      chk($sformatf("v%0d_wreg", i), mem_wreg, vecs[i].rwreg);
      chk($sformatf("v%0d_mis", i), mem_misalign, vecs[i].mis);
      chk($sformatf("v%0d_llwe", i), mem_LLbit_we, 0);
      chk($sformatf("v%0d_wd", i), mem_wd, 5);
      chk($sformatf("v%0d_hi", i), mem_hi, 32'h11);
      if (vecs[i].req) begin
        chk($sformatf("v%0d_we", i), bus_if.bus_we, vecs[i].we);
        chk($sformatf("v%0d_addr", i), bus_if.bus_addr, vecs[i].baddr);
        chk($sformatf("v%0d_sel", i), bus_if.bus_sel, vecs[i].sel);
        if (vecs[i].we)
          chk($sformatf("v%0d_bwd", i), bus_if.bus_wdata, vecs[i].bwdata);
      end
      if (vecs[i].chk_res)
        chk($sformatf("v%0d_res", i), mem_wdata, vecs[i].res);
      ex_mem_op = MEM_NONE;
      @(posedge clk);
      #1;
    end
    LLbit_i = 1'b0;
    wb_LLbit_we = 1'b0;

    for (int i = 0; i < 5; i++) begin
      set_op(lds[i].op, lds[i].addr, 32'h0, 1'b1);
      bus_if.bus_rdata = lds[i].rdata;
      access(2, n);
      chk($sformatf("ld%0d_stalls", i), n, 2);
      chk($sformatf("ld%0d_res", i), mem_wdata, lds[i].res);
      chk($sformatf("ld%0d_wreg", i), mem_wreg, 1);
      @(posedge clk);
      #1;
      ex_mem_op = MEM_NONE;
    end

    // LB with two WAIT cycles, then hold DONE under stall[4]
    set_op(MEM_LB, 32'h103, 32'h0, 1'b1);
    bus_if.bus_rdata = 32'h000000F0;
    access(3, n);
    chk("lb_stalls", n, 3);
    chk("lb_res", mem_wdata, 32'hFFFFFFF0);
    chk("lb_req_done", bus_if.bus_req, 0);
    stall[4] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("hold_req", bus_if.bus_req, 0);
    chk("hold_stall", stallreq_from_mem, 0);
    chk("hold_res", mem_wdata, 32'hFFFFFFF0);
    stall[4] = 1'b0;
    @(posedge clk);
    #1;
    ex_mem_op = MEM_NONE;

    // SH with ack in the first request cycle
    set_op(MEM_SH, 32'h202, 32'h0000ABCD, 1'b0);
    bus_if.bus_ack = 1'b1;
    #1;
    chk("sh_req", bus_if.bus_req, 1);
    chk("sh_we", bus_if.bus_we, 1);
    chk("sh_sel", bus_if.bus_sel, 4'b0011);
    chk("sh_wdata", bus_if.bus_wdata, 32'hABCDABCD);
    access(0, n);
    chk("sh_stalls", n, IMM_STALLS);
    @(posedge clk);
    #1;
    bus_if.bus_ack = 1'b0;
    ex_mem_op = MEM_NONE;

    // LW with immediate ack
    set_op(MEM_LW, 32'h8C, 32'h0, 1'b1);
    bus_if.bus_rdata = 32'h13579BDF;
    bus_if.bus_ack = 1'b1;
    access(0, n);
    chk("lwi_stalls", n, IMM_STALLS);
    chk("lwi_res", mem_wdata, 32'h13579BDF);
    @(posedge clk);
    #1;
    bus_if.bus_ack = 1'b0;
    ex_mem_op = MEM_NONE;

    // LL then SC, link forwarded from writeback
    set_op(MEM_LL, 32'h40, 32'h0, 1'b1);
    bus_if.bus_rdata = 32'h11223344;
    access(2, n);
    chk("ll_res", mem_wdata, 32'h11223344);
    chk("ll_llwe", mem_LLbit_we, 1);
    chk("ll_llval", mem_LLbit_value, 1);
    @(posedge clk);
    #1;
    set_op(MEM_SC, 32'h40, 32'h0000600D, 1'b1);
    LLbit_i = 1'b0;
    wb_LLbit_we = 1'b1;
    wb_LLbit_value = 1'b1;
    #1;
    chk("sc_req", bus_if.bus_req, 1);
    chk("sc_we", bus_if.bus_we, 1);
    chk("sc_addr", bus_if.bus_addr, 32'h40);
    chk("sc_bwd", bus_if.bus_wdata, 32'h0000600D);
    access(2, n);
    chk("sc_stalls", n, 2);
    chk("sc_res", mem_wdata, 1);
    chk("sc_wreg", mem_wreg, 1);
    chk("sc_llwe", mem_LLbit_we, 1);
    chk("sc_llval", mem_LLbit_value, 0);
    @(posedge clk);
    #1;
    ex_mem_op = MEM_NONE;
    wb_LLbit_we = 1'b0;

    // reset in WAIT, then a stray ack
    set_op(MEM_LW, 32'h80, 32'h0, 1'b1);
    @(negedge clk);
    chk("rw_stall", stallreq_from_mem, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rw_wait_req", bus_if.bus_req, 1);
    chk("rw_wait_addr", bus_if.bus_addr, 32'h80);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ex_mem_op = MEM_NONE;
    ex_wdata = 32'h99;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    chk("rw_req", bus_if.bus_req, 0);
    chk("rw_stall0", stallreq_from_mem, 0);
    chk("rw_pass", mem_wdata, 32'h99);
    @(posedge clk);
    #1;
    bus_if.bus_ack = 1'b0;
    set_op(MEM_LW, 32'h84, 32'h0, 1'b1);
    bus_if.bus_rdata = 32'h0BADF00D;
    access(2, n);
    chk("rw_stalls", n, 2);
    chk("rw_res", mem_wdata, 32'h0BADF00D);
    @(posedge clk);
    #1;
    ex_mem_op = MEM_NONE;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage of the 5-stage MIPS pipeline; sits between the ex_mem register and the mem_wb register.
- Passes ALU/HI/LO results through unchanged; executes LB/LBU/LH/LHU/LW/SB/SH/SW/LL/SC over a req/ack data bus.
- Raises a stall request until the bus access completes.
- Resolves the LL/SC link bit, with forwarding from the writeback stage.

Parameters:
- ADDR_W, 32, data bus address width.
- LLBIT_RST, 0, link bit reset value assumed by SC when no forwarding source is active.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  6  pipeline stall vector; bit 4 = mem_wb hold
- ex_wd  in  5  dest register
- ex_wdata  in  32  ALU result / store data source
- ex_wreg  in  1  reg write enable
- ex_whilo  in  1  hilo write enable
- ex_hi, ex_lo  in  32 each  hilo values
- ex_mem_op  in  4  mem_op_t code
- ex_mem_addr  in  ADDR_W  effective address
- ex_store_data  in  32  rt value
- LLbit_i  in  1  architectural link bit
- wb_LLbit_we, wb_LLbit_value  in  1 each  writeback forwarding
- bus_req  out  1  request
- bus_we  out  1  write
- bus_addr  out  ADDR_W  word-aligned address
- bus_sel  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data
- bus_ack  in  1  completion, sampled at posedge
- mem_wd, mem_wdata, mem_wreg, mem_whilo, mem_hi, mem_lo, mem_LLbit_we, mem_LLbit_value  out  as ex_*  to mem_wb
- mem_misalign  out  1  alignment fault flag
- stallreq_from_mem  out  1  to stall controller

Behaviour:
- Reset: state=IDLE. All outputs 0, including bus_req and stallreq_from_mem.
- States: IDLE, WAIT, DONE.
- Non-memory op (MEM_NONE): all mem_* outputs = ex_* combinationally; no stall; state stays IDLE.
- IDLE with aligned memory op:
  - bus_req=1 and stallreq_from_mem=1 combinationally.
  - bus_ack=1 at the edge: latch rdata and go to DONE. Otherwise go to WAIT.
- WAIT:
  - bus_req, addr, sel, we and wdata held stable; stallreq_from_mem=1.
  - bus_ack: latch rdata, go to DONE.
- DONE:
  - bus_req=0, stallreq_from_mem=0; outputs driven from latched data.
  - !stall[4]: return to IDLE (mem_wb captures on the same edge).
  - stall[4]=1: remain in DONE.
- Minimum latency: one stall cycle per memory op. Ack in the first request cycle gives the result in the following cycle.
- Byte lanes are big-endian (MIPS). addr[1:0]=0 selects bits 31:24.
  - Loads: byte/half extracted; sign-extended for LB/LH, zero-extended for LBU/LHU.
  - SB/SH: ex_store_data low byte/half replicated across all lanes; bus_sel one-hot (byte) or pair (half).
- Stores: mem_wreg passes ex_wreg, normally 0.
- Misalignment (LH/LHU/SH with addr[0]=1; LW/LL/SW/SC with addr[1:0]≠0):
  - no bus request; mem_misalign=1; mem_wreg=0; LLbit_we=0; no stall.
- LL: word load; mem_LLbit_we=1, mem_LLbit_value=1.
- SC: effective link = wb_LLbit_we ? wb_LLbit_value : LLbit_i.
  - Link=1: word store; mem_wdata=1; mem_LLbit_we=1, mem_LLbit_value=0.
  - Link=0: no bus access; mem_wdata=0; mem_wreg=1; no stall.
- Reset mid-access: bus_req drops in the cycle after rst is sampled; latched data is discarded. A late ack while IDLE with no request is ignored.

Optional Feature:
- MEM_LSU_FASTACK_EN defined:
  - in IDLE, a bus_ack in the same cycle as bus_req drives mem_wdata combinationally from bus_rdata;
  - stallreq_from_mem=0 that cycle; DONE is skipped (zero-stall access).
- Undefined: behaviour as above, with a registered result and one stall cycle minimum.

Decomposition:
- Shared package mem_pkg holds:
  - mem_op_t codes: NONE=0, LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC;
  - lsu_state_t;
  - constant WORD_ZERO.
- One sub-module: mem_align. Combinational byte-lane select/extend for loads and sel/replication for stores; shared by the load and store paths.

Test Plan:
- MEM_NONE, ex_wdata=0x1234, ex_wreg=1, wd=5 → same cycle mem_wdata=0x1234, mem_wd=5, no stall, bus_req=0.
- LB addr 0x103, rdata 0x000000F0, ack after 2 WAIT cycles → stallreq high 3 cycles; then mem_wdata=0xFFFFFFF0.
- SH addr 0x202, store_data 0xABCD, ack immediate → bus_sel=0011, bus_wdata=0xABCDABCD, we=1; one stall cycle.
- LL 0x40, then SC 0x40 with wb_LLbit_we=1/value=1 → SC stores; mem_wdata=1; LLbit_we=1, value=0.
- SC with LLbit_i=0 → no bus_req; mem_wdata=0, wreg=1. LW addr 0x2 → mem_misalign=1, wreg=0.
- rst asserted in WAIT → next cycle bus_req=0, state IDLE; later ack ignored. With MEM_LSU_FASTACK_EN and immediate ack, LW → zero stall cycles.
